// File: rtl/demux4_sched.sv
// ---------------------------------------------------------------------------
// demux4_sched
// Handshaked 1-to-4 stream scheduler. A one-entry holding register accepts
// items on a single valid/ready input and steers each one to exactly one of
// four consumers. The target is either an explicit select (fixed mode) or an
// internal round-robin pointer.
//
// Optional feature: define DEMUX4_SCHED_CNT_EN to add per-channel delivery
// counters on the deliv_cnt port (channel k at [k*CNT_W +: CNT_W]).
// ---------------------------------------------------------------------------
module demux4_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic               busy
`ifdef DEMUX4_SCHED_CNT_EN
    ,
    output logic [4*CNT_W-1:0] deliv_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Two-bit channel index to one-hot channel mask.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [1:0]         target_q, target_d;
    logic               mode_q,  mode_d;     // mode in force when the held item was captured
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [3:0]         out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               deliver_s;
    logic               capture_s;
    logic               in_ready_s;

    // Handshake decode: delivery on the target channel, and capture of a new item.
    always_comb begin
        deliver_s  = 1'b0;
        in_ready_s = 1'b0;
        capture_s  = 1'b0;
        if (state_q == ST_FULL) begin
            deliver_s  = out_ready[target_q];
            in_ready_s = out_ready[target_q];
        end else begin
            deliver_s  = 1'b0;
            in_ready_s = 1'b1;
        end
        capture_s = in_valid && in_ready_s;
    end

    // Next-state logic for the EMPTY/FULL holding register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (capture_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver_s && !capture_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next values: pointer advances first so a same-edge capture sees it.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        target_d = target_q;
        mode_d   = mode_q;
        if (deliver_s && mode_q) begin
            rr_ptr_d = target_q + 2'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (capture_s) begin
            data_d   = in_data;
            mode_d   = mode;
            if (mode) begin
                target_d = rr_ptr_d;
            end else begin
                target_d = sel;
            end
        end else begin
            data_d   = data_q;
            mode_d   = mode_q;
            target_d = target_q;
        end
    end

    // Output decode from next state so out_valid/busy leave flops directly.
    always_comb begin
        out_valid_d = 4'b0000;
        busy_d      = 1'b0;
        case (state_d)
            ST_EMPTY: begin
                out_valid_d = 4'b0000;
                busy_d      = 1'b0;
            end
            ST_FULL: begin
                out_valid_d = onehot4(target_d);
                busy_d      = 1'b1;
            end
            default: begin
                out_valid_d = 4'b0000;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Holding register, target, pointer and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= {WIDTH{1'b0}};
            target_q    <= 2'd0;
            mode_q      <= 1'b0;
            rr_ptr_q    <= 2'd0;
            out_valid_q <= 4'b0000;
            busy_q      <= 1'b0;
        end else begin
            data_q      <= data_d;
            target_q    <= target_d;
            mode_q      <= mode_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign in_ready  = in_ready_s;

`ifdef DEMUX4_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        // Per-channel delivery counter, wraps naturally at all-ones.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[k] <= {CNT_W{1'b0}};
            end else if (deliver_s && (target_q == 2'(k))) begin
                cnt_q[k] <= cnt_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_q[k] <= cnt_q[k];
            end
        end
        assign deliv_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_demux4_sched.sv
// ---------------------------------------------------------------------------
// tb_demux4_sched
// Directed-vector bench for demux4_sched with hand-computed expectations.
// Counter checks are compiled in when DEMUX4_SCHED_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_demux4_sched;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk_s;
    logic             rst_n_s;
    logic [WIDTH-1:0] in_data_s;
    logic             in_valid_s;
    logic             in_ready_s;
    logic             mode_s;
    logic [1:0]       sel_s;
    logic [WIDTH-1:0] out_data_s;
    logic [3:0]       out_valid_s;
    logic [3:0]       out_ready_s;
    logic             busy_s;
`ifdef DEMUX4_SCHED_CNT_EN
    logic [4*CNT_W-1:0] deliv_cnt_s;
`endif

    int n_vec_r;
    int n_err_r;

    demux4_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk_s),
        .rst_n     (rst_n_s),
        .in_data   (in_data_s),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .mode      (mode_s),
        .sel       (sel_s),
        .out_data  (out_data_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .busy      (busy_s)
`ifdef DEMUX4_SCHED_CNT_EN
        ,
        .deliv_cnt (deliv_cnt_s)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec_r++;
        if (obs !== exp_v) begin
            n_err_r++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    // Main stimulus.
    initial begin
        n_vec_r     = 0;
        n_err_r     = 0;
        rst_n_s     = 1'b0;
        in_data_s   = 8'h00;
        in_valid_s  = 1'b0;
        mode_s      = 1'b0;
        sel_s       = 2'd0;
        out_ready_s = 4'b0000;

        // 1. Reset then idle.
        #12;
        check_eq("rst_out_valid", 32'(out_valid_s), 32'h0);
        check_eq("rst_busy",      32'(busy_s),      32'h0);
        check_eq("rst_in_ready",  32'(in_ready_s),  32'h1);
        check_eq("rst_out_data",  32'(out_data_s),  32'h0);
        rst_n_s = 1'b1;
        tick();
        tick();
        check_eq("idle_out_valid", 32'(out_valid_s), 32'h0);
        check_eq("idle_busy",      32'(busy_s),      32'h0);

        // 2. Fixed mode, sel=2.
        mode_s = 1'b0; sel_s = 2'd2; in_data_s = 8'hA5; in_valid_s = 1'b1;
        out_ready_s = 4'b1111;
        tick();
        in_valid_s = 1'b0;
        check_eq("fix_out_valid", 32'(out_valid_s), 32'h4);
        check_eq("fix_out_data",  32'(out_data_s),  32'hA5);
        check_eq("fix_busy",      32'(busy_s),      32'h1);
        tick();
        check_eq("fix_drain_valid", 32'(out_valid_s), 32'h0);
        check_eq("fix_keep_data",   32'(out_data_s),  32'hA5);
        check_eq("fix_drain_busy",  32'(busy_s),      32'h0);

        // 3. Round-robin stream, pointer still 0 after the fixed delivery.
        mode_s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data_s  = 8'h10 + 8'(i);
            in_valid_s = 1'b1;
            #1;
            check_eq("rr_in_ready", 32'(in_ready_s), 32'h1);
            tick();
            check_eq("rr_out_valid", 32'(out_valid_s), 32'(4'b0001 << (i % 4)));
            check_eq("rr_out_data",  32'(out_data_s),  32'h10 + 32'(i));
        end
        in_valid_s = 1'b0;
        tick();
        check_eq("rr_drain", 32'(out_valid_s), 32'h0);

        // 1b. Reset pulsed while FULL.
        mode_s = 1'b0; sel_s = 2'd3; in_data_s = 8'h3C; in_valid_s = 1'b1;
        out_ready_s = 4'b0000;
        tick();
        in_valid_s = 1'b0;
        check_eq("pre_rst_valid", 32'(out_valid_s), 32'h8);
        rst_n_s = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid_s), 32'h0);
        check_eq("mid_rst_busy",  32'(busy_s),      32'h0);
        check_eq("mid_rst_data",  32'(out_data_s),  32'h0);
        rst_n_s = 1'b1;
        tick();
        check_eq("post_rst_valid", 32'(out_valid_s), 32'h0);

        // Bring pointer to 1 with one round-robin delivery on channel 0.
        mode_s = 1'b1; in_data_s = 8'h21; in_valid_s = 1'b1; out_ready_s = 4'b1111;
        tick();
        in_valid_s = 1'b0;
        check_eq("ptr0_valid", 32'(out_valid_s), 32'h1);
        tick();

        // 4. Stall on target 1 while other channels are ready.
        out_ready_s = 4'b1101; in_data_s = 8'h44; in_valid_s = 1'b1;
        tick();
        in_data_s = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_in_ready", 32'(in_ready_s),  32'h0);
            check_eq("stall_valid",    32'(out_valid_s), 32'h2);
            check_eq("stall_data",     32'(out_data_s),  32'h44);
            tick();
        end
        out_ready_s = 4'b0010;
        #1;
        check_eq("unstall_in_ready", 32'(in_ready_s), 32'h1);
        tick();
        in_valid_s = 1'b0;
        check_eq("unstall_next_valid", 32'(out_valid_s), 32'h4);
        check_eq("unstall_next_data",  32'(out_data_s),  32'h55);
        out_ready_s = 4'b1111;
        tick();

        // 5. Pointer now 3. Capture fixed target 0, then change sel before delivery.
        mode_s = 1'b0; sel_s = 2'd0; in_data_s = 8'h66; in_valid_s = 1'b1;
        out_ready_s = 4'b0000;
        tick();
        in_valid_s = 1'b0;
        sel_s = 2'd3;
        out_ready_s = 4'b1110;
        tick();
        check_eq("hold_valid", 32'(out_valid_s), 32'h1);
        check_eq("hold_data",  32'(out_data_s),  32'h66);
        out_ready_s = 4'b0001; in_data_s = 8'h77; in_valid_s = 1'b1;
        tick();
        in_valid_s = 1'b0;
        check_eq("resel_valid", 32'(out_valid_s), 32'h8);
        check_eq("resel_data",  32'(out_data_s),  32'h77);
        out_ready_s = 4'b1111;
        tick();
        mode_s = 1'b1; in_data_s = 8'h88; in_valid_s = 1'b1;
        tick();
        in_valid_s = 1'b0;
        check_eq("ptr_kept_valid", 32'(out_valid_s), 32'h8);
        tick();
        check_eq("final_empty", 32'(busy_s), 32'h0);

`ifdef DEMUX4_SCHED_CNT_EN
        // 6. Counter wrap: 17 deliveries to channel 1 with 4-bit counters.
        rst_n_s = 1'b0;
        #2;
        rst_n_s = 1'b1;
        mode_s = 1'b0; sel_s = 2'd1; out_ready_s = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            in_data_s  = 8'(i);
            in_valid_s = 1'b1;
            tick();
        end
        in_valid_s = 1'b0;
        tick();
        check_eq("cnt_ch0", 32'(deliv_cnt_s[0*CNT_W +: CNT_W]), 32'h0);
        check_eq("cnt_ch1", 32'(deliv_cnt_s[1*CNT_W +: CNT_W]), 32'h1);
        check_eq("cnt_ch2", 32'(deliv_cnt_s[2*CNT_W +: CNT_W]), 32'h0);
        check_eq("cnt_ch3", 32'(deliv_cnt_s[3*CNT_W +: CNT_W]), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec_r, n_err_r);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
